// File: rtl/mux_nto1_stream.sv
// N-input, W-bit stream multiplexer with per-channel valid/ready handshakes
// and a single registered output stage. MODE=0 picks the channel named by
// 'sel'; MODE=1 picks channels by round-robin starting at an internal pointer.
// Optional build macro MUX_STATS_EN adds a saturating 16-bit count of output
// handshakes on port xfer_cnt.
module mux_nto1_stream #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = 0,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready
`ifdef MUX_STATS_EN
    ,
    output logic [15:0]     xfer_cnt
`endif
);

    logic [W-1:0]    out_data_q;
    logic [W-1:0]    out_data_d;
    logic            out_valid_q;
    logic            out_valid_d;
    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] ptr_d;

    logic            grantValid;
    logic [SELW-1:0] grantIdx;
    logic [W-1:0]    grantData;
    logic            canLoad;
    logic            doLoad;
    logic            outFire;
    int              cand;

    // Pick the granted channel: either the external select (out-of-range
    // select means no grant rather than wrapping) or the first valid channel
    // scanning upward from the round-robin pointer. The scan runs from the
    // farthest offset back to the nearest so the nearest valid channel wins.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        cand       = 0;
        if (MODE == 0) begin
            if ((32'(sel) < 32'(N)) && in_valid[sel]) begin
                grantValid = 1'b1;
                grantIdx   = sel;
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                cand = (int'(ptr_q) + k) % N;
                if (in_valid[SELW'(cand)]) begin
                    grantValid = 1'b1;
                    grantIdx   = SELW'(cand);
                end
            end
        end
    end

    // Route the granted channel's data word toward the output register.
    always_comb begin
        grantData = '0;
        for (int i = 0; i < N; i++) begin
            if (grantIdx == SELW'(i)) begin
                grantData = in_data[i*W +: W];
            end
        end
    end

    assign canLoad = !out_valid_q || out_ready;
    assign doLoad  = !rst && canLoad && grantValid;
    assign outFire = out_valid_q && out_ready;

    // Only the granted channel sees ready, and only when the output register
    // can take a word this cycle; reset forces every ready low.
    always_comb begin
        in_ready = '0;
        if (doLoad) begin
            in_ready[grantIdx] = 1'b1;
        end
    end

    // Next-state for the output register and round-robin pointer: a load
    // replaces any draining word in the same edge, otherwise a drain empties it.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (doLoad) begin
            out_data_d  = grantData;
            out_valid_d = 1'b1;
            if (MODE == 1) begin
                ptr_d = (grantIdx == SELW'(N - 1)) ? '0 : grantIdx + 1'b1;
            end
        end else if (outFire) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and pointer state; reset discards any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef MUX_STATS_EN
    logic [15:0] xfer_cnt_q;
    logic [15:0] xfer_cnt_d;

    // Count output handshakes, sticking at all-ones instead of wrapping.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (outFire && (xfer_cnt_q != 16'hFFFF)) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
    end

    // Handshake counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Bench for mux_nto1_stream: one external-select instance (index 0) and one
// round-robin instance (index 1) run side by side against a behavioural model,
// plus directed literal checks. Build with MUX_STATS_EN to cover xfer_cnt.
module tb_mux_nto1_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] drvData  [2];
    logic [3:0]  drvValid [2];
    logic [1:0]  drvSel   [2];
    logic        drvReady [2];

    logic [3:0]  inReady  [2];
    logic [7:0]  outData  [2];
    logic        outValid [2];
`ifdef MUX_STATS_EN
    logic [15:0] xferCnt  [2];
`endif

    int testsRun = 0;
    int failures = 0;

    logic [7:0] seqAll [5];
    logic [7:0] seqOdd [4];

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    mux_nto1_stream #(.N(4), .W(8), .MODE(0)) dutSel (
        .clk       (clk),
        .rst       (rst),
        .in_data   (drvData[0]),
        .in_valid  (drvValid[0]),
        .in_ready  (inReady[0]),
        .sel       (drvSel[0]),
        .out_data  (outData[0]),
        .out_valid (outValid[0]),
        .out_ready (drvReady[0])
`ifdef MUX_STATS_EN
        ,
        .xfer_cnt  (xferCnt[0])
`endif
    );

    mux_nto1_stream #(.N(4), .W(8), .MODE(1)) dutRr (
        .clk       (clk),
        .rst       (rst),
        .in_data   (drvData[1]),
        .in_valid  (drvValid[1]),
        .in_ready  (inReady[1]),
        .sel       (drvSel[1]),
        .out_data  (outData[1]),
        .out_valid (outValid[1]),
        .out_ready (drvReady[1])
`ifdef MUX_STATS_EN
        ,
        .xfer_cnt  (xferCnt[1])
`endif
    );

    // ---------------- behavioural model ----------------
    logic [7:0] expData  [2];
    logic       expValid [2];
    int         expPtr   [2];
    int         expGrant [2];
    logic [3:0] expReady [2];
`ifdef MUX_STATS_EN
    logic [15:0] expCnt  [2];
`endif

    // Which channel the rules award: the selected one if valid, or the first
    // valid channel walking upward from the pointer; -1 when nobody wins.
    function automatic int grantOf(input int mode, input logic [3:0] v,
                                   input int s, input int p);
        if (mode == 0) begin
            if (s < 4 && v[s]) return s;
            return -1;
        end
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Expected grant and ready vector for both instances this cycle.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            expGrant[d] = grantOf(d, drvValid[d], int'(drvSel[d]), expPtr[d]);
            expReady[d] = 4'b0000;
            if (!rst && (!expValid[d] || drvReady[d]) && expGrant[d] >= 0)
                expReady[d] = 4'b0001 << expGrant[d];
        end
    end

    // Advance the model's output word, pointer and handshake count per edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                expData[d]  <= 8'h00;
                expValid[d] <= 1'b0;
                expPtr[d]   <= 0;
`ifdef MUX_STATS_EN
                expCnt[d]   <= 16'h0000;
`endif
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
`ifdef MUX_STATS_EN
                if (expValid[d] && drvReady[d] && expCnt[d] != 16'hFFFF)
                    expCnt[d] <= expCnt[d] + 16'd1;
`endif
                if (expReady[d] != 4'b0000) begin
                    expData[d]  <= drvData[d][expGrant[d]*8 +: 8];
                    expValid[d] <= 1'b1;
                    if (d == 1) expPtr[d] <= (expGrant[d] + 1) % 4;
                end else if (expValid[d] && drvReady[d]) begin
                    expValid[d] <= 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Every falling edge, hold both instances against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("model in_ready[%0d]", d),
                        32'(inReady[d]), 32'(expReady[d]));
            checkOutput($sformatf("model out_valid[%0d]", d),
                        32'(outValid[d]), 32'(expValid[d]));
            checkOutput($sformatf("model out_data[%0d]", d),
                        32'(outData[d]), 32'(expData[d]));
`ifdef MUX_STATS_EN
            checkOutput($sformatf("model xfer_cnt[%0d]", d),
                        32'(xferCnt[d]), 32'(expCnt[d]));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic applyStimulus(input int d, input logic [3:0] v,
                                 input logic [1:0] s, input logic r);
        drvValid[d] = v;
        drvSel[d]   = s;
        drvReady[d] = r;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic atNeg();
        @(negedge clk);
    endtask

    initial begin
        seqAll = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hAA};
        seqOdd = '{8'hBB, 8'hDD, 8'hBB, 8'hDD};
        for (int d = 0; d < 2; d++) begin
            drvData[d] = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
            applyStimulus(d, 4'b0000, 2'd0, 1'b0);
        end

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 32'(outValid[0]), 32'h0);
        checkOutput("reset out_data", 32'(outData[0]), 32'h00);
        checkOutput("reset in_ready", 32'(inReady[0]), 32'h0);
        rst = 1'b0;

        // External select: sel=2 then sel=0.
        applyStimulus(0, 4'b1111, 2'd2, 1'b1);
        atNeg();
        checkOutput("sel2 in_ready", 32'(inReady[0]), 32'b0100);
        stepCycle();
        applyStimulus(0, 4'b1111, 2'd0, 1'b1);
        atNeg();
        checkOutput("sel2 out_data", 32'(outData[0]), 32'hCC);
        checkOutput("sel2 out_valid", 32'(outValid[0]), 32'h1);
        stepCycle();
        atNeg();
        checkOutput("sel0 out_data", 32'(outData[0]), 32'hAA);

        // Backpressure: load CC, then stall five cycles.
        applyStimulus(0, 4'b1111, 2'd2, 1'b1);
        stepCycle();
        applyStimulus(0, 4'b1111, 2'd2, 1'b0);
        atNeg();
        checkOutput("stall in_ready", 32'(inReady[0]), 32'h0);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            atNeg();
            checkOutput("stall out_data", 32'(outData[0]), 32'hCC);
            checkOutput("stall out_valid", 32'(outValid[0]), 32'h1);
            checkOutput("stall in_ready", 32'(inReady[0]), 32'h0);
        end

        // Release with only ch1 valid: same-edge replace.
        applyStimulus(0, 4'b0010, 2'd1, 1'b1);
        atNeg();
        checkOutput("replace in_ready", 32'(inReady[0]), 32'b0010);
        stepCycle();
        applyStimulus(0, 4'b0010, 2'd3, 1'b1);
        atNeg();
        checkOutput("replace out_data", 32'(outData[0]), 32'hBB);
        checkOutput("replace out_valid", 32'(outValid[0]), 32'h1);
        checkOutput("nogrant in_ready", 32'(inReady[0]), 32'h0);
        stepCycle();
        atNeg();
        checkOutput("drain out_valid", 32'(outValid[0]), 32'h0);
        checkOutput("drain out_data", 32'(outData[0]), 32'hBB);

        // Round-robin fairness with every channel valid.
        applyStimulus(1, 4'b1111, 2'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            atNeg();
            checkOutput("rr all out_data", 32'(outData[1]), 32'(seqAll[i]));
            checkOutput("rr all model", 32'(expData[1]), 32'(seqAll[i]));
        end
        applyStimulus(1, 4'b1010, 2'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            atNeg();
            checkOutput("rr odd out_data", 32'(outData[1]), 32'(seqOdd[i]));
        end

        // Wrap: move pointer to 3 via ch2, then ch3 before ch0, then ch1.
        applyStimulus(1, 4'b0100, 2'd0, 1'b1);
        stepCycle();
        applyStimulus(1, 4'b1001, 2'd0, 1'b1);
        atNeg();
        checkOutput("wrap setup", 32'(outData[1]), 32'hCC);
        checkOutput("wrap ready ch3", 32'(inReady[1]), 32'b1000);
        stepCycle();
        atNeg();
        checkOutput("wrap first", 32'(outData[1]), 32'hDD);
        stepCycle();
        applyStimulus(1, 4'b1111, 2'd0, 1'b1);
        atNeg();
        checkOutput("wrap second", 32'(outData[1]), 32'hAA);
        stepCycle();
        atNeg();
        checkOutput("wrap ptr1", 32'(outData[1]), 32'hBB);

        // Reset while a word is held under backpressure.
        applyStimulus(1, 4'b1111, 2'd0, 1'b0);
        stepCycle();
        rst = 1'b1;
        #1;
        checkOutput("midrst out_valid", 32'(outValid[1]), 32'h0);
        checkOutput("midrst out_data", 32'(outData[1]), 32'h00);
        checkOutput("midrst in_ready", 32'(inReady[1]), 32'h0);
        stepCycle();
        rst = 1'b0;
        applyStimulus(1, 4'b1111, 2'd0, 1'b1);
        stepCycle();
        atNeg();
        checkOutput("postrst first", 32'(outData[1]), 32'hAA);

`ifdef MUX_STATS_EN
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        repeat (11) stepCycle();
        atNeg();
        checkOutput("cnt ten", 32'(xferCnt[1]), 32'd10);
        repeat (65540) stepCycle();
        atNeg();
        checkOutput("cnt saturate", 32'(xferCnt[1]), 32'hFFFF);
        stepCycle();
        rst = 1'b1;
        #1;
        checkOutput("cnt reset", 32'(xferCnt[1]), 32'h0);
        stepCycle();
        rst = 1'b0;
`endif

        repeat (2) stepCycle();
        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule
